// File: rtl/window_fetcher_seq_if.sv
// Handshake and tag bundle between a pixel source, window_fetcher_seq and the window fetcher.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface window_fetcher_seq_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                  start_i;
    logic [DATA_WIDTH-1:0] pix_data_i;
    logic                  pix_valid_i;
    logic                  pix_ready_o;
    logic [DATA_WIDTH-1:0] fet_data_o;
    logic [15:0]           fet_col_o;
    logic [15:0]           fet_row_o;
    logic                  fet_valid_o;
    logic [15:0]           win_col_i;
    logic [15:0]           win_row_i;
    logic                  win_valid_i;
    logic                  win_accept_o;
    logic                  busy_o;
    logic                  frame_done_o;

    modport slave (
        input  start_i, pix_data_i, pix_valid_i, win_col_i, win_row_i, win_valid_i,
        output pix_ready_o, fet_data_o, fet_col_o, fet_row_o, fet_valid_o, win_accept_o,
               busy_o, frame_done_o
    );

    modport master (
        output start_i, pix_data_i, pix_valid_i, win_col_i, win_row_i, win_valid_i,
        input  pix_ready_o, fet_data_o, fet_col_o, fet_row_o, fet_valid_o, win_accept_o,
               busy_o, frame_done_o
    );
endinterface

// File: rtl/window_fetcher_seq.sv
// Frame sequencer for window_fetcher: tags pixels, injects end-of-frame flush pushes, counts windows.
// Optional macro WINDOW_FETCHER_SEQ_STALL_CNT_EN adds the stall_cycles_o counter output.
module window_fetcher_seq #(
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           IMAGE_WIDTH  = 64,
    parameter int unsigned           IMAGE_HEIGHT = 64,
    parameter int unsigned           FLUSH_COUNT  = 65,
    parameter logic [DATA_WIDTH-1:0] FLUSH_DATA   = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
`ifdef WINDOW_FETCHER_SEQ_STALL_CNT_EN
    output logic [31:0]        stall_cycles_o,
`endif
    window_fetcher_seq_if.slave bus
);

    localparam logic [31:0] NumPix    = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [15:0] ColLast   = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] RowLast   = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] ColTag    = 16'(IMAGE_WIDTH);
    localparam logic [15:0] RowTag    = 16'(IMAGE_HEIGHT);
    localparam logic [31:0] FlushLast = (FLUSH_COUNT == 0) ? 32'd0 : 32'(FLUSH_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StStream, StFlush, StDrain} state_e;

    state_e                state_q, state_d;
    logic [15:0]           col_q, col_d;
    logic [15:0]           row_q, row_d;
    logic [31:0]           flush_q, flush_d;
    logic [31:0]           win_cnt_q, win_cnt_d;
    logic                  fet_valid_q, fet_valid_d;
    logic [DATA_WIDTH-1:0] fet_data_q, fet_data_d;
    logic [15:0]           fet_col_q, fet_col_d;
    logic [15:0]           fet_row_q, fet_row_d;
    logic                  done_q, done_d;

    logic pix_ready;
    logic handshake;
    logic accept;
    logic last_accept;

    assign pix_ready   = (state_q == StStream);
    assign handshake   = pix_ready & bus.pix_valid_i;
    // Flush tags sit just outside the frame, so they are never counted as windows.
    assign accept      = bus.win_valid_i && (state_q != StIdle) && (bus.win_col_i < ColTag) &&
                         (bus.win_row_i < RowTag) && (win_cnt_q < NumPix);
    assign last_accept = accept && (win_cnt_q == NumPix - 32'd1);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        flush_d     = flush_q;
        win_cnt_d   = win_cnt_q;
        fet_valid_d = 1'b0;
        fet_data_d  = fet_data_q;
        fet_col_d   = fet_col_q;
        fet_row_d   = fet_row_q;
        done_d      = last_accept;

        if (accept) begin
            win_cnt_d = win_cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    state_d   = StStream;
                    col_d     = '0;
                    row_d     = '0;
                    flush_d   = '0;
                    win_cnt_d = '0;
                end
            end
            StStream: begin
                if (handshake) begin
                    fet_valid_d = 1'b1;
                    fet_data_d  = bus.pix_data_i;
                    fet_col_d   = col_q;
                    fet_row_d   = row_q;
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            row_d   = '0;
                            flush_d = '0;
                            state_d = (FLUSH_COUNT > 0) ? StFlush : StDrain;
                        end else begin
                            row_d = row_q + 16'd1;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            StFlush: begin
                fet_valid_d = 1'b1;
                fet_data_d  = FLUSH_DATA;
                fet_col_d   = ColTag;
                fet_row_d   = RowTag;
                flush_d     = flush_q + 32'd1;
                if (flush_q == FlushLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave on the final accept itself so IDLE lines up with the frame_done pulse.
                if ((win_cnt_q == NumPix) || last_accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            flush_q     <= '0;
            win_cnt_q   <= '0;
            fet_valid_q <= 1'b0;
            fet_data_q  <= '0;
            fet_col_q   <= '0;
            fet_row_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            flush_q     <= flush_d;
            win_cnt_q   <= win_cnt_d;
            fet_valid_q <= fet_valid_d;
            fet_data_q  <= fet_data_d;
            fet_col_q   <= fet_col_d;
            fet_row_q   <= fet_row_d;
            done_q      <= done_d;
        end
    end

`ifdef WINDOW_FETCHER_SEQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == StIdle) && bus.start_i) begin
            stall_d = '0;
        end else if ((state_q == StStream) && !bus.pix_valid_i && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

    assign bus.pix_ready_o  = pix_ready;
    assign bus.fet_valid_o  = fet_valid_q;
    assign bus.fet_data_o   = fet_data_q;
    assign bus.fet_col_o    = fet_col_q;
    assign bus.fet_row_o    = fet_row_q;
    assign bus.win_accept_o = accept;
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.frame_done_o = done_q;

endmodule

// File: doc/window_fetcher_seq.md
Name: window_fetcher_seq

Overview:
Frame sequencer in front of window_fetcher. It accepts an untagged pixel stream over a ready/valid handshake and tags each pixel with col/row. At end of frame it injects flush pushes so the fetcher's push-in-to-push-out lag drains and every window of the frame is emitted before the next frame starts. It also qualifies and counts the fetcher's window outputs and signals frame completion.

Parameters:
DATA_WIDTH, 16, pixel width; must match the fetcher.
IMAGE_WIDTH, 64, pixels per row (>=2, <=32767).
IMAGE_HEIGHT, 64, rows per frame (>=2, <=32767).
FLUSH_COUNT, 65, flush pushes per frame; integrator sets to rev_row*IMAGE_WIDTH + rev_col of the fetcher's offset centre; 0 allowed; must be < IMAGE_WIDTH*IMAGE_HEIGHT.
FLUSH_DATA, 0, DATA_WIDTH-bit value driven on flush pushes.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous assert, active-low
start_i  in  1  arm one frame; sampled in IDLE only
pix_data_i  in  DATA_WIDTH  upstream pixel
pix_valid_i  in  1  upstream valid
pix_ready_o  out  1  upstream ready
fet_data_o  out  DATA_WIDTH  to fetcher data_i
fet_col_o  out  16  to fetcher col_i
fet_row_o  out  16  to fetcher row_i
fet_valid_o  out  1  to fetcher valid_i
win_col_i  in  16  fetcher col_o
win_row_i  in  16  fetcher row_o
win_valid_i  in  1  fetcher valid_o
win_accept_o  out  1  qualified window strobe, combinational from win_valid_i and win count
busy_o  out  1  high outside IDLE
frame_done_o  out  1  one-cycle pulse, last window of frame accepted

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all counters 0; pix_ready_o=0, fet_valid_o=0, fet_data_o=0, fet_col_o=0, fet_row_o=0, busy_o=0, frame_done_o=0. Deassertion takes effect synchronously on the next clk_i edge. Reset mid-frame discards the frame; the fetcher must be reset alongside.
- All fet_* outputs are registered, so latency from pixel handshake to fet_valid_o is 1 cycle. The fetcher has no backpressure, and at most one push per cycle.
- State IDLE: pix_ready_o=0. If start_i=1, go to STREAM; col_cnt=row_cnt=0; win_cnt=0.
- State STREAM: pix_ready_o=1.
  - On handshake (valid&ready): next cycle fet_valid_o=1, fet_data_o=pix_data_i, fet_col_o=col_cnt, fet_row_o=row_cnt.
  - col_cnt increments and wraps at IMAGE_WIDTH-1 to 0, incrementing row_cnt.
  - Handshake at (IMAGE_WIDTH-1, IMAGE_HEIGHT-1): pix_ready_o drops the next cycle. If FLUSH_COUNT>0 go to FLUSH with flush_cnt=0, else go to DRAIN.
  - No handshake: fet_valid_o=0, counters hold.
- State FLUSH: pix_ready_o=0.
  - Every cycle: fet_valid_o=1, fet_data_o=FLUSH_DATA, fet_col_o=IMAGE_WIDTH, fet_row_o=IMAGE_HEIGHT. These out-of-range tags never trigger the fetcher's start-of-frame resync.
  - After FLUSH_COUNT pushes go to DRAIN.
- State DRAIN: fet_valid_o=0. Wait until win_cnt reaches IMAGE_WIDTH*IMAGE_HEIGHT, then go to IDLE.
- Window qualification, in any non-IDLE state: win_accept_o = win_valid_i & (win_col_i<IMAGE_WIDTH) & (win_row_i<IMAGE_HEIGHT) & (win_cnt<IMAGE_WIDTH*IMAGE_HEIGHT). Each accept increments win_cnt (32-bit, no wrap). Windows in IDLE are not accepted.
- frame_done_o: registered pulse the cycle after the accept that makes win_cnt = IMAGE_WIDTH*IMAGE_HEIGHT. The state returns to IDLE in the same cycle, so busy_o=0 then.
- The final window may arrive during FLUSH when the fetcher lag is smaller than FLUSH_COUNT. The remaining flush pushes still complete, then DRAIN exits immediately.
- start_i asserted outside IDLE is ignored. start_i held high in IDLE starts back-to-back frames with no dead cycle beyond the IDLE cycle.

Optional Feature:
WINDOW_FETCHER_SEQ_STALL_CNT_EN.
- Defined: adds output stall_cycles_o [31:0]. It counts STREAM cycles with pix_valid_i=0, clears on the start_i accept in IDLE, saturates at 2^32-1, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Base config for all scenarios: 8x4 image, 3x3 window with zero offsets, FLUSH_COUNT=9.
- Ramp with data=index, valid always high: exactly 32 pushes with col 0..7, row 0..3, then 9 flush pushes with col=8, row=4, data=0. 32 win_accept_o pulses in raster order (col,row), then frame_done_o one pulse, then IDLE.
- Random pix_valid_i gaps, 50% duty: fet_valid_o toggles only on handshakes; tags and the 32-window count are unchanged; with STALL_CNT_EN, stall_cycles_o equals the number of gap cycles.
- Two frames, start_i held high: second frame tags restart at (0,0). The fetcher emits no windows with stale frame-1 tags before frame-2 window (0,0). Total 64 accepts and 2 frame_done_o pulses.
- rst_ni pulled low at pixel 13 of a frame: all outputs go to 0 immediately, without a clock edge. A subsequent start_i gives a clean 32-window frame.
- FLUSH_COUNT=0 with a 1x1 window: no flush pushes. STREAM goes directly to DRAIN, and frame_done_o pulses one cycle after the 32nd accept.
